// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory and decode-side signals of the fetch unit.
`timescale 1ns/1ps
interface instr_fetch_if;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemRdata;
  logic [15:0] instr;
  logic        instrVld;
  logic [15:0] instrPc;
  logic        decRdy;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        hlt;
  logic        halted;
  modport master (
    output imemReq, imemAddr, instr, instrVld, instrPc, halted,
    input  imemAck, imemRdata, decRdy, redirect, redirectPc, hlt
  );
  modport slave (
    input  imemReq, imemAddr, instr, instrVld, instrPc, halted,
    output imemAck, imemRdata, decRdy, redirect, redirectPc, hlt
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding fetch feeding a FIFO toward decode.
// Define FETCH_BUF2_EN for a 2-entry buffer; otherwise the buffer holds 1 entry.
`timescale 1ns/1ps
module instr_fetch (
  input logic clk,
  input logic rst,
  instr_fetch_if.master bus
);
`ifdef FETCH_BUF2_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif
  localparam logic [1:0] RUN = 2'd0, WAIT = 2'd1, DRAIN = 2'd2, HALT = 2'd3;
  logic [1:0] st, cnt;
  logic [15:0] pc, tgt, hdInstr, hdPc;
  logic toHalt, go, ack, flush, push, pop;
  assign flush = bus.redirect | bus.hlt;
  assign bus.instrVld = cnt != 2'd0;
  assign pop = bus.instrVld & bus.decRdy & ~flush;
  // go holds off the first request until one edge after reset releases
  assign bus.imemReq = go & (st == WAIT | st == DRAIN | (st == RUN & ~flush & (cnt < DEPTH | pop)));
  assign ack = bus.imemReq & bus.imemAck;
  assign push = ack & ~flush & (st == RUN | st == WAIT);
  assign bus.imemAddr = pc;
  assign bus.instr = hdInstr;
  assign bus.instrPc = hdPc;
  assign bus.halted = st == HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= RUN;
      pc <= '0;
      tgt <= '0;
      toHalt <= 1'b0;
      go <= 1'b0;
    end else begin
      go <= 1'b1;
      case (st)
        RUN:
          if (bus.hlt) st <= HALT;
          else if (bus.redirect) pc <= bus.redirectPc;
          else if (bus.imemReq) begin
            if (ack) pc <= pc + 16'd1;
            else st <= WAIT;
          end
        WAIT:
          if (bus.hlt) begin
            st <= ack ? HALT : DRAIN;
            toHalt <= 1'b1;
          end else if (bus.redirect) begin
            st <= ack ? RUN : DRAIN;
            pc <= ack ? bus.redirectPc : pc;
            tgt <= bus.redirectPc;
            toHalt <= 1'b0;
          end else if (ack) begin
            st <= RUN;
            pc <= pc + 16'd1;
          end
        DRAIN: begin
          // pc keeps the abandoned address on the bus until its ack arrives
          if (bus.hlt) toHalt <= 1'b1;
          else if (bus.redirect) tgt <= bus.redirectPc;
          if (ack) begin
            st <= (toHalt | bus.hlt) ? HALT : RUN;
            pc <= bus.redirect ? bus.redirectPc : tgt;
          end
        end
        default: ;
      endcase
    end
  end
`ifdef FETCH_BUF2_EN
  logic [15:0] tlInstr, tlPc;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      hdInstr <= '0;
      hdPc <= '0;
      tlInstr <= '0;
      tlPc <= '0;
    end else begin
      cnt <= flush ? 2'd0 : cnt + 2'(push) - 2'(pop);
      if (push & (cnt == 2'd0 | (cnt == 2'd1 & pop))) {hdInstr, hdPc} <= {bus.imemRdata, pc};
      else if (pop) {hdInstr, hdPc} <= {tlInstr, tlPc};
      if (push & (cnt == 2'd2 | (cnt == 2'd1 & ~pop))) {tlInstr, tlPc} <= {bus.imemRdata, pc};
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      hdInstr <= '0;
      hdPc <= '0;
    end else begin
      cnt <= flush ? 2'd0 : cnt + 2'(push) - 2'(pop);
      if (push) {hdInstr, hdPc} <= {bus.imemRdata, pc};
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against a latency-programmable memory model.
`timescale 1ns/1ps
module tb_instr_fetch;
`ifdef FETCH_BUF2_EN
  localparam logic DEP2 = 1'b1;
`else
  localparam logic DEP2 = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nChecks = 0, nErrors = 0, memLat = 0, waitCnt = 0;
  logic sReq, sVld, sHalted;
  logic [15:0] sAddr, sInstr, sPc;
  instr_fetch_if bus();
  instr_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // one clock cycle: drive inputs, answer the memory, sample mid-cycle
  task automatic step(input logic dr, input logic rd, input logic [15:0] rpc, input logic h);
    bus.decRdy = dr;
    bus.redirect = rd;
    bus.redirectPc = rpc;
    bus.hlt = h;
    #1;
    if (rst || !bus.imemReq) begin
      bus.imemAck = 1'b0;
      waitCnt = 0;
    end else if (waitCnt >= memLat) begin
      bus.imemAck = 1'b1;
      waitCnt = 0;
    end else begin
      bus.imemAck = 1'b0;
      waitCnt++;
    end
    bus.imemRdata = bus.imemAddr | 16'hA000;
    #1;
    sReq = bus.imemReq;
    sAddr = bus.imemAddr;
    sVld = bus.instrVld;
    sInstr = bus.instr;
    sPc = bus.instrPc;
    sHalted = bus.halted;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.imemAck = 1'b0;
    bus.imemRdata = '0;
    repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst_req", 16'(sReq), 16'd0);
    chk("rst_addr", sAddr, 16'h0);
    chk("rst_vld", 16'(sVld), 16'd0);
    chk("rst_instr", sInstr, 16'h0);
    chk("rst_pc", sPc, 16'h0);
    chk("rst_halted", 16'(sHalted), 16'd0);
    rst = 1'b0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rel_req", 16'(sReq), 16'd0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("first_req", 16'(sReq), 16'd1);
    chk("first_addr", sAddr, 16'h0);
    chk("first_vld", 16'(sVld), 16'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      chk("stream_vld", 16'(sVld), 16'd1);
      chk("stream_instr", sInstr, 16'hA000 + 16'(i));
      chk("stream_pc", sPc, 16'(i));
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("stall_vld", 16'(sVld), 16'd1);
      chk("stall_instr", sInstr, 16'hA003);
      chk("stall_req", 16'(sReq), i == 0 ? 16'(DEP2) : 16'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      chk("release_vld", 16'(sVld), 16'd1);
      chk("release_instr", sInstr, 16'hA003 + 16'(i));
      chk("release_pc", sPc, 16'd3 + 16'(i));
    end
    step(1'b1, 1'b1, 16'h0100, 1'b0);
    chk("redir_req", 16'(sReq), 16'd0);
    memLat = 3;
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      chk("slow_addr", sAddr, 16'h0100 + 16'(j / 4));
      chk("slow_req", 16'(sReq), 16'd1);
      chk("slow_vld", 16'(sVld), j == 4 ? 16'd1 : 16'd0);
      if (j == 4) chk("slow_instr", sInstr, 16'hA100);
    end
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("slow2_vld", 16'(sVld), 16'd1);
    chk("slow2_instr", sInstr, 16'hA101);
    step(1'b1, 1'b1, 16'h0005, 1'b0);
    chk("drain_req", 16'(sReq), 16'd1);
    chk("drain_addr", sAddr, 16'h0102);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("drain_hold", sAddr, 16'h0102);
    chk("drain_vld", 16'(sVld), 16'd0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("drain_ackaddr", sAddr, 16'h0102);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("tgt5_addr", sAddr, 16'h0005);
    chk("tgt5_vld", 16'(sVld), 16'd0);
    step(1'b1, 1'b1, 16'h0040, 1'b0);
    chk("pend5_addr", sAddr, 16'h0005);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("disc5_addr", sAddr, 16'h0005);
    chk("disc5_vld", 16'(sVld), 16'd0);
    memLat = 0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("tgt40_addr", sAddr, 16'h0040);
    chk("tgt40_vld", 16'(sVld), 16'd0);
    step(1'b1, 1'b1, 16'hFFFF, 1'b0);
    chk("tgt40_out_vld", 16'(sVld), 16'd1);
    chk("tgt40_out_pc", sPc, 16'h0040);
    chk("tgt40_out_instr", sInstr, 16'hA040);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("top_addr", sAddr, 16'hFFFF);
    chk("top_vld", 16'(sVld), 16'd0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("top_instr", sInstr, 16'hFFFF);
    chk("top_pc", sPc, 16'hFFFF);
    chk("wrap_addr", sAddr, 16'h0000);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("wrap_instr", sInstr, 16'hA000);
    chk("wrap_pc", sPc, 16'h0000);
    memLat = 2;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("prehlt_instr", sInstr, 16'hA001);
    step(1'b1, 1'b1, 16'h0040, 1'b1);
    chk("hlt_req", 16'(sReq), 16'd1);
    chk("hlt_addr", sAddr, 16'h0002);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("hltdrain_req", 16'(sReq), 16'd1);
    chk("hltdrain_addr", sAddr, 16'h0002);
    chk("hltdrain_halted", 16'(sHalted), 16'd0);
    chk("hltdrain_vld", 16'(sVld), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'(i % 2), 16'h0080, 1'b0);
      chk("halt_halted", 16'(sHalted), 16'd1);
      chk("halt_req", 16'(sReq), 16'd0);
      chk("halt_vld", 16'(sVld), 16'd0);
    end
    rst = 1'b1;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst2_halted", 16'(sHalted), 16'd0);
    chk("rst2_req", 16'(sReq), 16'd0);
    rst = 1'b0;
    memLat = 3;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst2_first_req", 16'(sReq), 16'd1);
    chk("rst2_first_addr", sAddr, 16'h0);
    rst = 1'b1;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("abandon_req", 16'(sReq), 16'd0);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
